// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled START/STOP detection, 7-bit address match,
// byte receive with ACK, byte transmit on request. Open-drain SDA, no clock stretching.
module i2c_target #(
  parameter logic [6:0] OWN_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_WR_DATA  = 3'd3,
    S_WR_ACK   = 3'd4,
    S_RD_DATA  = 3'd5,
    S_RD_ACK   = 3'd6
  } state_t;

  state_t      state;
  logic        scl_m, scl_s, scl_p;
  logic        sda_m, sda_s, sda_p;
  logic        sda_oe;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [6:0]  tx_sh;
  logic        rw;
  logic        ack_bit;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  sh_next;

  // Open-drain: only ever pull low or let go.
  assign I2C_SDA   = sda_oe ? 1'b0 : 1'bz;
  assign state_dbg = state;

  // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_p <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_m <= I2C_SCL;
      scl_s <= scl_m;
      scl_p <= scl_s;
      sda_m <= I2C_SDA;
      sda_s <= sda_m;
      sda_p <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign sh_next   = {shreg[6:0], sda_s};

  // ack_bit marks that the SCL rising edge of the current ACK slot has been seen,
  // so the first falling edge in an ACK state starts the slot and the second ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sda_oe    <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      tx_sh     <= 7'h00;
      rw        <= 1'b0;
      ack_bit   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addressed <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= 3'd0;
        ack_bit   <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
        addressed <= 1'b0;
      end else if (stop_det) begin
        state     <= S_IDLE;
        bit_cnt   <= 3'd0;
        ack_bit   <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        addressed <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sda_oe <= 1'b0;
          end
          S_ADDR: begin
            if (scl_rise) begin
              shreg   <= sh_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (sh_next[7:1] == OWN_ADDR) begin
                  addressed <= 1'b1;
                  rw        <= sh_next[0];
                  ack_bit   <= 1'b0;
                  state     <= S_ADDR_ACK;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_rise) begin
              ack_bit <= 1'b1;
              if (rw) tx_req <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_bit) begin
                sda_oe <= 1'b1;
              end else begin
                ack_bit <= 1'b0;
                bit_cnt <= 3'd0;
                if (rw) begin
                  tx_sh  <= tx_data[6:0];
                  sda_oe <= ~tx_data[7];
                  state  <= S_RD_DATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= S_WR_DATA;
                end
              end
            end
          end
          S_WR_DATA: begin
            if (scl_rise) begin
              shreg   <= sh_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= sh_next;
                rx_valid <= 1'b1;
                ack_bit  <= 1'b0;
                state    <= S_WR_ACK;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_rise) begin
              ack_bit <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_bit) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                ack_bit <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_bit <= 1'b0;
                state   <= S_RD_ACK;
              end
            end else if (scl_fall) begin
              sda_oe <= ~tx_sh[6];
              tx_sh  <= {tx_sh[5:0], 1'b1};
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= S_IDLE;
              end else begin
                ack_bit <= 1'b1;
                tx_req  <= 1'b1;
              end
            end else if (scl_fall) begin
              if (!ack_bit) begin
                sda_oe <= 1'b0;
              end else begin
                ack_bit <= 1'b0;
                bit_cnt <= 3'd0;
                tx_sh   <= tx_data[6:0];
                sda_oe  <= ~tx_data[7];
                state   <= S_RD_DATA;
              end
            end
          end
          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C initiator, rx scoreboard, tx byte feeder.
module tb_i2c_target;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       addressed;
  logic       busy;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int req_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_src_q[$];

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I2C_SCL   (scl),
    .I2C_SDA   (sda_bus),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .addressed (addressed),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and tx feeder, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (tx_req) begin
      req_cnt++;
      if (tx_src_q.size() > 0) tx_data = tx_src_q.pop_front();
    end
  end

  task automatic i2c_start;
    m_sda = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_sda = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    m_sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    ack = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1;
      #Q; d[i] = sda_bus;
      #Q; scl = 1'b0;
      #Q;
    end
    send_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] abort_byte;
    int         rx0;
    int         rq0;

    // Reset
    repeat (4) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_addressed", 32'(addressed), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0x12, 0x34
    rx0 = rx_cnt;
    i2c_start();
    check("wr_busy_start", 32'(busy), 32'd1);
    check("wr_addr_start", 32'(addressed), 32'd0);
    write_byte(8'hA0, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    check("wr_addressed", 32'(addressed), 32'd1);
    exp_q.push_back(8'h12);
    write_byte(8'h12, ack);
    check("wr_ack1", 32'(ack), 32'd0);
    exp_q.push_back(8'h34);
    write_byte(8'h34, ack);
    check("wr_ack2", 32'(ack), 32'd0);
    i2c_stop();
    check("wr_busy_stop", 32'(busy), 32'd0);
    check("wr_addr_stop", 32'(addressed), 32'd0);
    check("wr_state_stop", 32'(state_dbg), 32'd0);
    check("wr_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("wr_rx_hold", 32'(rx_data), 32'h34);

    // Read 0xC3 (ACK), 0x5A (NACK)
    rq0 = req_cnt;
    tx_src_q.push_back(8'hC3);
    tx_src_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    read_byte(1'b0, d);
    check("rd_byte0", 32'(d), 32'hC3);
    read_byte(1'b1, d);
    check("rd_byte1", 32'(d), 32'h5A);
    check("rd_sda_released", 32'(sda_bus), 32'd1);
    check("rd_state_nack", 32'(state_dbg), 32'd0);
    check("rd_addressed_nack", 32'(addressed), 32'd1);
    i2c_stop();
    check("rd_req_count", 32'(req_cnt - rq0), 32'd2);
    check("rd_busy_stop", 32'(busy), 32'd0);

    // Address mismatch
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hB0, ack);
    check("mm_addr_nack", 32'(ack), 32'd1);
    check("mm_addressed", 32'(addressed), 32'd0);
    write_byte(8'h12, ack);
    check("mm_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    check("mm_rx_count", 32'(rx_cnt - rx0), 32'd0);

    // Write then repeated START into a read
    rx0 = rx_cnt;
    rq0 = req_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("sr_wr_addr_ack", 32'(ack), 32'd0);
    exp_q.push_back(8'h07);
    write_byte(8'h07, ack);
    check("sr_wr_ack", 32'(ack), 32'd0);
    i2c_start();
    check("sr_busy", 32'(busy), 32'd1);
    tx_src_q.push_back(8'h99);
    write_byte(8'hA1, ack);
    check("sr_rd_addr_ack", 32'(ack), 32'd0);
    check("sr_addressed", 32'(addressed), 32'd1);
    read_byte(1'b1, d);
    check("sr_rd_byte", 32'(d), 32'h99);
    check("sr_addressed_hold", 32'(addressed), 32'd1);
    i2c_stop();
    check("sr_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("sr_req_count", 32'(req_cnt - rq0), 32'd1);

    // STOP after 4 data bits discards the partial byte
    rx0 = rx_cnt;
    abort_byte = 8'h00 | 8'($urandom_range(0, 255));
    i2c_start();
    write_byte(8'hA0, ack);
    check("ab_addr_ack", 32'(ack), 32'd0);
    for (int i = 7; i >= 4; i--) send_bit(abort_byte[i]);
    i2c_stop();
    check("ab_rx_count", 32'(rx_cnt - rx0), 32'd0);
    check("ab_state", 32'(state_dbg), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);

    // Reset asserted while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5 ? 1'b1 : 1'b0);
    m_sda = 1'b1;
    #1;
    check("ra_ack_driven", 32'(sda_bus), 32'd0);
    rst_n = 1'b0;
    #1;
    check("ra_sda_released", 32'(sda_bus), 32'd1);
    check("ra_state", 32'(state_dbg), 32'd0);
    check("ra_busy", 32'(busy), 32'd0);
    check("ra_addressed", 32'(addressed), 32'd0);
    check("ra_rx_data", 32'(rx_data), 32'h00);
    check("ra_rx_valid", 32'(rx_valid), 32'd0);
    check("ra_tx_req", 32'(tx_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_byte(8'hA0, ack);
    check("ra_ignore_no_start", 32'(ack), 32'd1);
    check("ra_ignore_state", 32'(state_dbg), 32'd0);
    i2c_stop();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
